mem_arbiter: RTL and testbench
==============================

Name:
mem_arbiter

Overview:
- Shares the single paddr SRAM port between the instruction fetch master (M0, read-only) and the load/store master (M1, read/write).
- Uses a valid/ready request channel and a valid/ready response channel on every side.
- Allows one outstanding transaction, round-robin arbitration and a response timeout; it sits between the IFU/LSU and the SRAM wrapper in the NPC top.

Parameters:
ADDR_W, 32, address width (data fixed 32 bit, wmask 8 bit as in paddr_write)
TIMEOUT, 255, max cycles waiting for slave response; 0 disables timeout

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
m0_req_valid  in  1  IFU read request valid
m0_req_ready  out  1  IFU request accepted
m0_addr  in  ADDR_W  IFU read address
m0_rsp_valid  out  1  IFU response valid
m0_rsp_ready  in  1  IFU can take response
m0_rdata  out  32  IFU read data
m1_req_valid  in  1  LSU request valid
m1_req_ready  out  1  LSU request accepted
m1_addr  in  ADDR_W  LSU address
m1_wen  in  1  1=write, 0=read
m1_wdata  in  32  LSU write data
m1_wmask  in  8  LSU byte mask
m1_rsp_valid  out  1  LSU response valid
m1_rsp_ready  in  1  LSU can take response
m1_rdata  out  32  LSU read data (0 for writes)
rsp_err  out  1  error flag, qualified by m0_rsp_valid or m1_rsp_valid
s_req_valid  out  1  request to SRAM valid
s_req_ready  in  1  SRAM accepts request
s_addr  out  ADDR_W  forwarded address
s_wen  out  1  forwarded write enable (0 when M0 granted)
s_wdata  out  32  forwarded write data
s_wmask  out  8  forwarded mask (0 when M0 granted)
s_rsp_valid  in  1  SRAM response valid
s_rsp_ready  out  1  arbiter takes SRAM response
s_rdata  in  32  SRAM read data

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to IDLE, grant=M0, last_grant=M1 (so M0 wins first), timeout counter=0.
  - All valid/ready outputs are 0 except s_rsp_ready=1; rsp_err=0; all data outputs are 0.
  - Any in-flight transaction is abandoned without a response.
- IDLE:
  - If exactly one m*_req_valid is set, register it as grant and go to REQ.
  - If both are set, grant the master that is not last_grant.
  - Arbitration costs one cycle. No m*_req_ready is asserted in IDLE.
  - s_rsp_ready=1 here so stray late responses are drained and discarded.
- REQ:
  - Payload is forwarded combinationally from the granted master: s_req_valid = granted req_valid; granted m*_req_ready = s_req_ready; the other master's ready=0.
  - On s_req_valid&s_req_ready, clear the counter and go to RSP.
  - If the granted req_valid drops before the handshake, return to IDLE with no response. last_grant is unchanged.
- RSP:
  - s_rsp_ready = granted m*_rsp_ready; granted m*_rsp_valid = s_rsp_valid; m*_rdata = s_rdata; rsp_err=0.
  - On the response handshake: last_grant=grant and go to IDLE. A new grant is possible the following cycle.
  - The counter increments each RSP cycle. If TIMEOUT!=0 and the counter reaches TIMEOUT with s_rsp_valid=0 on that cycle, go to ERR.
  - If s_rsp_valid and the timeout occur on the same cycle, the response wins.
- ERR:
  - Granted m*_rsp_valid=1, rsp_err=1, rdata=0, s_rsp_ready=1 (drain).
  - On the granted m*_rsp_ready: last_grant=grant and go to IDLE.
- General:
  - The ungranted master always sees req_ready=0 and rsp_valid=0.
  - The counter is 8 bits wide and saturates; it never wraps.
  - Masters hold payload stable while valid&!ready.

Test Plan:
- Single M0 read, addr=0x80000000, SRAM ready immediately, returns 0x00000413 next cycle → m0_rsp_valid with rdata=0x00000413, rsp_err=0. Request-to-response latency is 3 cycles (1 arbitration, 1 request, 1 response).
- M0 and M1 request in the same cycle after reset → M0 served first, then M1. Repeated continuous requests from both alternate M0, M1, M0, M1 with no starvation.
- M1 write addr=0x80001000, wdata=0xDEADBEEF, wmask=0x0F → s_wen=1, s_wmask=0x0F, s_wdata=0xDEADBEEF; M1 receives a response with rdata=0.
- TIMEOUT=4, slave never asserts s_rsp_valid → after 4 RSP cycles the granted master sees rsp_valid=1, rsp_err=1, rdata=0. A late s_rsp_valid is accepted by s_rsp_ready=1 and not forwarded.
- Backpressure: s_req_ready low for 5 cycles, then m1_rsp_ready low for 3 cycles → payload held stable, exactly one response delivered, no duplicate response.
- rst pulsed low while in RSP → outputs go to reset values immediately (asynchronous); the next request arbitrates from IDLE with M0 priority.

Source files
------------

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-master round-robin arbiter for a single SRAM port with response timeout
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_valid,
    output logic              m0_req_ready,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic              m0_rsp_valid,
    input  logic              m0_rsp_ready,
    output logic [31:0]       m0_rdata,
    input  logic              m1_req_valid,
    output logic              m1_req_ready,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic              m1_wen,
    input  logic [31:0]       m1_wdata,
    input  logic [7:0]        m1_wmask,
    output logic              m1_rsp_valid,
    input  logic              m1_rsp_ready,
    output logic [31:0]       m1_rdata,
    output logic              rsp_err,
    output logic              s_req_valid,
    input  logic              s_req_ready,
    output logic [ADDR_W-1:0] s_addr,
    output logic              s_wen,
    output logic [31:0]       s_wdata,
    output logic [7:0]        s_wmask,
    input  logic              s_rsp_valid,
    output logic              s_rsp_ready,
    input  logic [31:0]       s_rdata
);
    localparam logic [7:0] TMO = (TIMEOUT > 255) ? 8'hFF : TIMEOUT[7:0];

    typedef enum logic [1:0] {IDLE, REQ, RSP, ERR} state_t;

    state_t     state_q;
    logic       grant_q;
    logic       last_q;
    logic       wr_q;
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       g_req_valid;
    logic       g_rsp_ready;
    logic       g_wen;

    assign g_req_valid = grant_q ? m1_req_valid : m0_req_valid;
    assign g_rsp_ready = grant_q ? m1_rsp_ready : m0_rsp_ready;
    assign g_wen       = grant_q & m1_wen;
    assign cnt_d       = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            grant_q <= 1'b0;
            last_q  <= 1'b1;
            wr_q    <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (m0_req_valid || m1_req_valid) begin
                        grant_q <= (m0_req_valid && m1_req_valid) ? ~last_q : m1_req_valid;
                        state_q <= REQ;
                    end
                end
                REQ: begin
                    // a withdrawn request is dropped silently and does not count as service
                    if (!g_req_valid) begin
                        state_q <= IDLE;
                    end else if (s_req_ready) begin
                        cnt_q   <= 8'd0;
                        wr_q    <= g_wen;
                        state_q <= RSP;
                    end
                end
                RSP: begin
                    if (s_rsp_valid && g_rsp_ready) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (TMO != 8'd0 && !s_rsp_valid && cnt_d == TMO)
                            state_q <= ERR;
                    end
                end
                ERR: begin
                    if (g_rsp_ready) begin
                        last_q  <= grant_q;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_comb begin
        m0_req_ready = 1'b0;
        m1_req_ready = 1'b0;
        m0_rsp_valid = 1'b0;
        m1_rsp_valid = 1'b0;
        m0_rdata     = 32'd0;
        m1_rdata     = 32'd0;
        rsp_err      = 1'b0;
        s_req_valid  = 1'b0;
        s_addr       = '0;
        s_wen        = 1'b0;
        s_wdata      = 32'd0;
        s_wmask      = 8'd0;
        // with nothing outstanding, any response from the slave is stray and gets drained
        s_rsp_ready  = 1'b1;
        case (state_q)
            REQ: begin
                s_req_valid = g_req_valid;
                s_wen       = g_wen;
                if (grant_q) begin
                    m1_req_ready = s_req_ready;
                    s_addr       = m1_addr;
                    s_wdata      = m1_wdata;
                    s_wmask      = m1_wmask;
                end else begin
                    m0_req_ready = s_req_ready;
                    s_addr       = m0_addr;
                end
            end
            RSP: begin
                s_rsp_ready = g_rsp_ready;
                if (grant_q) begin
                    m1_rsp_valid = s_rsp_valid;
                    m1_rdata     = wr_q ? 32'd0 : s_rdata;
                end else begin
                    m0_rsp_valid = s_rsp_valid;
                    m0_rdata     = s_rdata;
                end
            end
            ERR: begin
                rsp_err = 1'b1;
                if (grant_q) m1_rsp_valid = 1'b1;
                else         m0_rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        m0_req_valid, m0_req_ready, m0_rsp_valid, m0_rsp_ready;
    logic [31:0] m0_addr, m0_rdata;
    logic        m1_req_valid, m1_req_ready, m1_wen, m1_rsp_valid, m1_rsp_ready;
    logic [31:0] m1_addr, m1_wdata, m1_rdata;
    logic [7:0]  m1_wmask;
    logic        rsp_err, s_req_valid, s_req_ready, s_wen, s_rsp_valid, s_rsp_ready;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [7:0]  s_wmask;

    mem_arbiter #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_ready(m0_rsp_ready), .m0_rdata(m0_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
        .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_ready(m1_rsp_ready), .m1_rdata(m1_rdata),
        .rsp_err(rsp_err),
        .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
        .s_wen(s_wen), .s_wdata(s_wdata), .s_wmask(s_wmask),
        .s_rsp_valid(s_rsp_valid), .s_rsp_ready(s_rsp_ready), .s_rdata(s_rdata)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic m0v, m1v, m1w, sqr, srv;
        logic [31:0] srd;
        logic m0rsr, m1rsr;
    } ins_t;
    typedef struct packed {
        logic m0qr, m1qr, m0rv, m1rv, err, sqv, srr, swen;
        logic [7:0] swm;
        logic [31:0] sad, swd, r0, r1;
    } outs_t;
    typedef struct { ins_t i; outs_t o; } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t vt[15];

    function automatic ins_t mk_i(input logic m0v, m1v, m1w, sqr, srv, input logic [31:0] srd,
                                  input logic m0rsr, m1rsr);
        return '{m0v, m1v, m1w, sqr, srv, srd, m0rsr, m1rsr};
    endfunction

    function automatic outs_t mk_o(input logic m0qr, m1qr, m0rv, m1rv, err, sqv, srr, swen,
                                   input logic [7:0] swm, input logic [31:0] sad, swd, r0, r1);
        return '{m0qr, m1qr, m0rv, m1rv, err, sqv, srr, swen, swm, sad, swd, r0, r1};
    endfunction

    function automatic outs_t get_o();
        return '{m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, rsp_err, s_req_valid,
                 s_rsp_ready, s_wen, s_wmask, s_addr, s_wdata, m0_rdata, m1_rdata};
    endfunction

    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic apply(input ins_t x);
        m0_req_valid = x.m0v;  m0_addr  = 32'h8000_0000;
        m1_req_valid = x.m1v;  m1_addr  = 32'h8000_1000;  m1_wen = x.m1w;
        m1_wdata     = 32'hDEAD_BEEF;  m1_wmask = 8'h0F;
        s_req_ready  = x.sqr;  s_rsp_valid = x.srv;  s_rdata = x.srd;
        m0_rsp_ready = x.m0rsr;  m1_rsp_ready = x.m1rsr;
    endtask

    outs_t idle_o;
    logic [31:0] q0[$], q1[$];
    logic [31:0] a0, a1, d1, sl_addr, exp_d;
    logic [7:0]  k1;
    logic        w1, act0, act1, sl_busy, sl_w;
    int since0, since1, last_srv, sl_dly, nresp, cyc;
    int last_hs[2];

    initial begin
        idle_o = mk_o(0,0,0,0,0,0,1,0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        vt[0]  = '{mk_i(1,1,1,1,0,32'h0,1,1), idle_o};
        vt[1]  = '{mk_i(1,1,1,1,0,32'h0,1,1), mk_o(1,0,0,0,0,1,1,0, 8'h0, 32'h8000_0000, 32'h0, 32'h0, 32'h0)};
        vt[2]  = '{mk_i(0,1,1,1,1,32'h413,1,1), mk_o(0,0,1,0,0,0,1,0, 8'h0, 32'h0, 32'h0, 32'h413, 32'h0)};
        vt[3]  = '{mk_i(0,1,1,1,0,32'h0,1,1), idle_o};
        vt[4]  = '{mk_i(0,1,1,1,0,32'h0,1,1), mk_o(0,1,0,0,0,1,1,1, 8'h0F, 32'h8000_1000, 32'hDEAD_BEEF, 32'h0, 32'h0)};
        vt[5]  = '{mk_i(0,0,0,1,1,32'h1234_5678,1,1), mk_o(0,0,0,1,0,0,1,0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0)};
        vt[6]  = '{mk_i(1,0,0,1,0,32'h0,1,1), idle_o};
        vt[7]  = '{mk_i(1,0,0,1,0,32'h0,1,1), mk_o(1,0,0,0,0,1,1,0, 8'h0, 32'h8000_0000, 32'h0, 32'h0, 32'h0)};
        for (int i = 8; i < 12; i++)
            vt[i] = '{mk_i(0,0,0,1,0,32'h0,1,1), idle_o};
        vt[12] = '{mk_i(0,0,0,1,1,32'hBAD,0,1), mk_o(0,0,1,0,1,0,1,0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0)};
        vt[13] = '{mk_i(0,0,0,1,0,32'h0,1,1), mk_o(0,0,1,0,1,0,1,0, 8'h0, 32'h0, 32'h0, 32'h0, 32'h0)};
        vt[14] = '{mk_i(0,0,0,1,1,32'hBAD,1,1), idle_o};

        rst = 1'b0;
        apply(mk_i(0,0,0,0,0,32'h0,0,0));
        repeat (3) @(negedge clk);
        chk("reset_state", get_o(), idle_o);
        rst = 1'b1;

        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            apply(vt[i].i);
            @(negedge clk);
            chk($sformatf("vec%0d", i), get_o(), vt[i].o);
        end

        // M1 read stalled by the slave, then by the master's response ready
        @(posedge clk); #1;
        m1_req_valid = 1; m1_wen = 0; m1_addr = 32'h8000_2000; m1_wmask = 8'h0;
        s_req_ready = 0; s_rsp_valid = 0; m0_req_valid = 0; m1_rsp_ready = 1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("bp_req_hold", {s_req_valid, m1_req_ready, s_addr}, {2'b10, 32'h8000_2000});
        end
        @(posedge clk); #1; s_req_ready = 1;
        @(negedge clk);
        chk("bp_req_accept", {s_req_valid, m1_req_ready}, 2'b11);
        @(posedge clk); #1;
        m1_req_valid = 0; s_rsp_valid = 1; s_rdata = 32'hCAFE_F00D; m1_rsp_ready = 0;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("bp_rsp_hold", {m1_rsp_valid, m1_rdata, s_rsp_ready}, {1'b1, 32'hCAFE_F00D, 1'b0});
        end
        nresp = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1; m1_rsp_ready = 1;
            @(negedge clk);
            if (m1_rsp_valid && m1_rsp_ready) nresp++;
        end
        chk("bp_single_rsp", nresp, 1);

        // complete an M0 access so M1 would win next, then reset mid-RSP of an M1 access
        @(posedge clk); #1;
        s_rsp_valid = 0; m0_req_valid = 1; m0_addr = 32'h8000_0000; s_req_ready = 1; m0_rsp_ready = 1;
        @(posedge clk); #1;
        @(posedge clk); #1; m0_req_valid = 0; s_rsp_valid = 1; s_rdata = 32'h1;
        @(posedge clk); #1; s_rsp_valid = 0; m1_req_valid = 1; m1_wen = 0;
        @(posedge clk); #1;
        @(posedge clk); #1; m1_req_valid = 0; s_rsp_valid = 1; s_rdata = 32'h77; m1_rsp_ready = 0;
        @(negedge clk);
        chk("rst_pre_rsp", {m1_rsp_valid, m1_rdata}, {1'b1, 32'h77});
        #2 rst = 1'b0;
        #1 chk("rst_async", get_o(), idle_o);
        @(posedge clk); #1; s_rsp_valid = 0; m0_req_valid = 1; m1_req_valid = 1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_m0_first", {s_req_valid, m0_req_ready, m1_req_ready, s_addr}, {3'b110, 32'h8000_0000});
        @(posedge clk); #1; m0_req_valid = 0; m1_req_valid = 0; rst = 1'b0;
        @(negedge clk); rst = 1'b1;

        // randomized traffic against a transaction-level scoreboard
        act0 = 0; act1 = 0; sl_busy = 0; sl_w = 0; sl_addr = 0; sl_dly = 0; last_srv = -1;
        a0 = 0; a1 = 0; d1 = 0; k1 = 0; w1 = 0; since0 = 0; since1 = 0;
        last_hs[0] = 0; last_hs[1] = 0;
        for (cyc = 0; cyc < 3400; cyc++) begin
            if (cyc >= 3000 && !act0 && !act1 && !sl_busy && q0.size() == 0 && q1.size() == 0) break;
            @(posedge clk); #1;
            if (!act0 && cyc < 3000 && $urandom_range(0, 1) == 1) begin
                act0 = 1; since0 = cyc; a0 = {16'h8000, 14'($urandom), 2'b00};
            end
            if (!act1 && cyc < 3000 && $urandom_range(0, 1) == 1) begin
                act1 = 1; since1 = cyc; a1 = {16'h9000, 14'($urandom), 2'b00};
                w1 = 1'($urandom_range(0, 1)); d1 = $urandom; k1 = 8'($urandom);
            end
            m0_req_valid = act0; m0_addr = a0;
            m1_req_valid = act1; m1_addr = a1; m1_wen = w1; m1_wdata = d1; m1_wmask = k1;
            s_req_ready  = ($urandom_range(0, 3) != 0);
            s_rsp_valid  = sl_busy && (sl_dly == 0);
            s_rdata      = (s_rsp_valid && !sl_w) ? mem_f(sl_addr) : $urandom;
            m0_rsp_ready = ($urandom_range(0, 3) != 0);
            m1_rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (m0_rsp_valid || m1_rsp_valid)
                chk("one_rsp_at_a_time", {m0_rsp_valid, m1_rsp_valid, rsp_err}, {m0_rsp_valid & ~m1_rsp_valid, m1_rsp_valid & ~m0_rsp_valid, 1'b0});
            if (m0_rsp_valid && m0_rsp_ready) begin
                exp_d = (q0.size() != 0) ? q0.pop_front() : 32'hXXXX_XXXX;
                chk("m0_rsp_data", m0_rdata, exp_d);
            end
            if (m1_rsp_valid && m1_rsp_ready) begin
                exp_d = (q1.size() != 0) ? q1.pop_front() : 32'hXXXX_XXXX;
                chk("m1_rsp_data", m1_rdata, exp_d);
            end
            if (m0_req_valid && m0_req_ready) begin
                q0.push_back(mem_f(a0));
                chk("fair_m0", (last_srv == 0 && act1 && since1 <= last_hs[0]), 0);
                last_srv = 0; last_hs[0] = cyc; act0 = 0;
            end
            if (m1_req_valid && m1_req_ready) begin
                q1.push_back(w1 ? 32'h0 : mem_f(a1));
                chk("fair_m1", (last_srv == 1 && act0 && since0 <= last_hs[1]), 0);
                last_srv = 1; last_hs[1] = cyc; act1 = 0;
            end
            if (s_rsp_valid && s_rsp_ready) sl_busy = 0;
            else if (sl_busy && sl_dly > 0) sl_dly--;
            if (s_req_valid && s_req_ready) begin
                chk("one_outstanding", sl_busy, 0);
                if (s_addr[28])
                    chk("s_payload_m1", {s_addr, s_wen, s_wdata, s_wmask}, {a1, w1, d1, k1});
                else
                    chk("s_payload_m0", {s_addr, s_wen, s_wdata, s_wmask}, {a0, 1'b0, 32'h0, 8'h0});
                sl_busy = 1; sl_addr = s_addr; sl_w = s_wen; sl_dly = $urandom_range(0, 2);
            end
        end
        chk("drain_complete", {32'(q0.size()), 32'(q1.size()), act0, act1, sl_busy}, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
